// File: rtl/sum_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : sum_uart_tx
// Description : Adds the two latched operands and, on a falling edge of the
//               send pushbutton, transmits the zero-extended sum as a single
//               8N1 UART frame (LSB first) on tx.
// Ports       : clk      - system clock, rising edge
//               reset_n  - asynchronous active-low reset
//               q_a, q_b - DATA_W-bit unsigned operands from the latch
//               send_n   - active-low send request (asynchronous pushbutton)
//               tx       - UART serial out, idle high, registered
//               busy     - high from START entry through the last STOP cycle
//               done     - one-cycle pulse after the stop bit completes
//               sum_out  - sum captured when the frame started
// Revision    : 1.0 - initial release
// ============================================================================
module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_W       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] q_a,
    input  logic [DATA_W-1:0] q_b,
    input  logic              send_n,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [DATA_W:0]   sum_out
);

    localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // Request synchronizer and edge detector
    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic [1:0] r_seen;
    logic       r_armed;
    logic       w_req;

    // Datapath and FSM
    logic [DATA_W:0]    w_sum;
    logic [7:0]         w_payload;
    logic               w_bit_end;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_baud;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;
    logic [DATA_W:0]    r_sum;

    assign w_sum     = {1'b0, q_a} + {1'b0, q_b};
    assign w_payload = 8'(w_sum);
    assign w_bit_end = (r_baud == c_CNT_LAST);

    // The sync flops reset high so an untouched button is not a request.
    // r_seen marks when r_s2 first carries a genuinely sampled value; the
    // detector is armed only once the button has been seen released, so a
    // button already held down when reset is released cannot fire a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_s3    <= 1'b1;
            r_seen  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_s1    <= send_n;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_seen  <= {r_seen[0], 1'b1};
            r_armed <= r_armed | (r_seen[1] & r_s2);
        end
    end

    assign w_req = r_s3 & ~r_s2 & r_armed;

    // Frame FSM. tx is updated on the same edge as the state so the line
    // level always matches the bit being sent and comes straight off a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_baud  <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_baud <= '0;
                    if (w_req) begin
                        r_shift <= w_payload;
                        r_sum   <= w_sum;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_idx   <= 3'd0;
                        r_tx    <= r_shift[0];
                        r_state <= c_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_STOP;
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                            r_idx   <= r_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                c_STOP: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_baud  <= '0;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sum_out = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_sum_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_uart_tx
// Description : Self-checking bench for sum_uart_tx with CLKS_PER_BIT=4.
//               Expected sums are queued when a send is driven; a monitor
//               decodes each tx frame and compares it against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_uart_tx;

    localparam int c_CPB   = 4;
    localparam int c_DW    = 4;
    localparam int c_FRAME = 10 * c_CPB;

    logic            clk;
    logic            reset_n;
    logic [c_DW-1:0] q_a;
    logic [c_DW-1:0] q_b;
    logic            send_n;
    logic            tx;
    logic            busy;
    logic            done;
    logic [c_DW:0]   sum_out;

    int checks;
    int errors;
    int frames_seen;
    logic [c_DW:0] sb[$];

    sum_uart_tx #(
        .CLKS_PER_BIT(c_CPB),
        .DATA_W      (c_DW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .q_a    (q_a),
        .q_b    (q_b),
        .send_n (send_n),
        .tx     (tx),
        .busy   (busy),
        .done   (done),
        .sum_out(sum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a press just after a rising edge and verify tx falls on the
    // third rising edge counting the one that first samples send_n=0.
    task automatic send_timed(input bit do_push, input logic [c_DW:0] exp_sum);
        if (do_push) sb.push_back(exp_sum);
        send_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("tx_before_start", tx, 1'b1);
        @(negedge clk);
        check_val("tx_start_edge", tx, 1'b0);
    endtask

    // Frame monitor: samples each bit in its middle cycle.
    initial begin : monitor
        logic [9:0]    bits;
        logic [c_DW:0] exp;
        bit            busy_ok;
        bit            aborted;
        bit            chk_done_next;
        frames_seen   = 0;
        chk_done_next = 1'b0;
        bits          = '0;
        forever begin
            @(negedge clk);
            if (chk_done_next) begin
                check_val("done_width", done, 1'b0);
                chk_done_next = 1'b0;
            end
            if (reset_n === 1'b1 && tx === 1'b0) begin
                busy_ok = 1'b1;
                aborted = 1'b0;
                for (int c = 0; c < c_FRAME; c++) begin
                    if (reset_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
                    if (c % c_CPB == c_CPB / 2) bits[c / c_CPB] = tx;
                    @(negedge clk);
                end
                if (aborted) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    wait (reset_n === 1'b1);
                end else begin
                    check_val("done_at_end", done, 1'b1);
                    check_val("busy_at_end", busy, 1'b0);
                    check_val("busy_during", busy_ok, 1'b1);
                    check_val("start_bit", bits[0], 1'b0);
                    check_val("stop_bit", bits[9], 1'b1);
                    if (sb.size() == 0) begin
                        check_val("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        exp = sb.pop_front();
                        check_val("frame_byte", bits[8:1], 8'(exp));
                        check_val("sum_out", sum_out, exp);
                    end
                    frames_seen++;
                    chk_done_next = 1'b1;
                end
            end
        end
    end

    initial begin : stim
        int  f0;
        bit  ok;
        reset_n = 1'b0;
        send_n  = 1'b1;
        q_a     = '0;
        q_b     = '0;

        // Reset held with the button released
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sum_out !== '0) ok = 1'b0;
        end
        check_val("reset_idle", ok, 1'b1);
        tick(1);
        reset_n = 1'b1;
        tick(5);
        check_val("idle_tx", tx, 1'b1);
        check_val("idle_sum", sum_out, 5'd0);

        // Basic frame 3+5
        f0  = frames_seen;
        q_a = 4'd3;
        q_b = 4'd5;
        tick(1);
        send_timed(1'b1, 5'd8);
        tick(3);
        send_n = 1'b1;
        tick(45);
        check_val("basic_frames", frames_seen - f0, 1);

        // Max sum, operand changed mid-frame
        f0  = frames_seen;
        q_a = 4'd15;
        q_b = 4'd15;
        tick(1);
        send_timed(1'b1, 5'h1E);
        tick(3);
        send_n = 1'b1;
        tick(8);
        q_a = 4'd0;
        tick(40);
        check_val("sum_hold", sum_out, 5'h1E);
        check_val("max_frames", frames_seen - f0, 1);

        // Button held 200 cycles gives one frame
        f0  = frames_seen;
        q_a = 4'd2;
        q_b = 4'd7;
        tick(1);
        send_timed(1'b1, 5'd9);
        tick(200);
        send_n = 1'b1;
        tick(5);
        check_val("held_frames", frames_seen - f0, 1);

        // Second press while busy is dropped
        f0  = frames_seen;
        q_a = 4'd1;
        q_b = 4'd1;
        tick(1);
        send_timed(1'b1, 5'd2);
        tick(2);
        send_n = 1'b1;
        tick(5);
        send_n = 1'b0;
        tick(5);
        send_n = 1'b1;
        tick(50);
        check_val("busy_press_frames", frames_seen - f0, 1);

        // Back-to-back: second request lands in the first idle cycle
        f0  = frames_seen;
        q_a = 4'd9;
        q_b = 4'd6;
        tick(1);
        sb.push_back(5'd15);
        send_n = 1'b0;
        tick(20);
        send_n = 1'b1;
        tick(21);
        send_timed(1'b1, 5'd15);
        tick(3);
        send_n = 1'b1;
        tick(50);
        check_val("b2b_frames", frames_seen - f0, 2);

        // Reset during DATA bit 3 with the button still held
        f0  = frames_seen;
        q_a = 4'd5;
        q_b = 4'd4;
        tick(1);
        send_timed(1'b1, 5'd9);
        tick(17);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_tx", tx, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_sum", sum_out, 5'd0);
        tick(3);
        reset_n = 1'b1;
        ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
        end
        check_val("no_frame_after_rst", ok, 1'b1);
        check_val("rst_frames", frames_seen - f0, 0);
        tick(1);
        send_n = 1'b1;
        tick(6);
        f0 = frames_seen;
        send_timed(1'b1, 5'd9);
        tick(2);
        send_n = 1'b1;
        tick(50);
        check_val("repress_frames", frames_seen - f0, 1);

        check_val("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sum_uart_tx.md
Name: sum_uart_tx

Overview:
- Downstream stage of the 2x8 operand latch.
- Consumes the two latched 4-bit operands (q_a, q_b), adds them, and on a user send request transmits the 5-bit sum as one 8N1 UART frame on a single tx line.
- Sits between the latch outputs and the board's serial pin.
- Provides busy/done status and a registered copy of the transmitted sum.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (104 = 9600 baud at 1 MHz); legal range >= 2.
- DATA_W, 4, width of each operand; the sum is DATA_W+1 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- q_a  input  DATA_W  operand A from latch (unsigned, quasi-static).
- q_b  input  DATA_W  operand B from latch (unsigned, quasi-static).
- send_n  input  1  active-low send request (pushbutton level, asynchronous to clk).
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at end of stop bit.
- sum_out  output  DATA_W+1  sum captured at frame start.

Behaviour:
- Reset (async, reset_n=0), all outputs registered and forced immediately:
  - tx=1, busy=0, done=0, sum_out=0.
  - FSM=IDLE, baud counter=0, bit index=0.
  - Synchronizer flops set to 1, so a released button reads as no request.
- Request path:
  - send_n passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - Request = s3 & ~s2, i.e. a falling edge of send_n; it lasts one cycle.
  - Holding send_n low produces exactly one request. A new one requires release (>= 3 cycles high), then press again.
- Arithmetic:
  - sum = q_a + q_b, zero-extended, DATA_W+1 bits, no overflow possible (default max 15+15=30=0x1E).
  - Payload byte = {(8-DATA_W-1) zeros, sum}, sent LSB first.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. On a request, load shift reg with payload, sum_out<=sum, baud counter<=0, go START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. On each bit end, shift right and increment index. After index 7 completes, go STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, done=1 for that one cycle, busy=0, go IDLE.
- Timing:
  - busy=1 from the cycle START is entered through the last STOP cycle.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - tx drops to 0 on the 3rd rising clk edge after the first edge that samples send_n=0.
- Requests arriving while busy=1 are dropped, not queued.
- A request in the first IDLE cycle after done is accepted; back-to-back frames have a 1-cycle idle gap minimum.
- q_a/q_b changes after capture do not affect the frame in flight; sum_out holds until the next capture.
- Baud counter wraps CLKS_PER_BIT-1 -> 0 on every bit boundary. No fractional accumulation.
- Reset asserted mid-frame aborts immediately: tx=1 in the same instant, no done pulse. After release, the block waits for a fresh falling edge. If send_n is already low at release, no frame is sent.
- tx is driven from a flop, so it is glitch-free.

Test Plan (CLKS_PER_BIT=4):
- Reset then idle: reset_n low, send_n=1 for 100 cycles -> tx=1, busy=0, done=0, sum_out=0 throughout.
- Basic frame: q_a=3, q_b=5, pulse send_n low -> sum_out=8; tx samples per bit = 0, 0,0,0,1,0,0,0,0, 1 (byte 0x08); busy high 40 cycles; done one pulse at cycle 40.
- Max sum, and operands changed mid-frame: q_a=15, q_b=15, send, then change q_a=0 during DATA -> byte 0x1E sent, sum_out stays 0x1E.
- Held button and press while busy: send_n held low 200 cycles -> exactly one frame. Second falling edge during the frame -> ignored, no second frame.
- Back-to-back: release then press so the request lands in the first IDLE cycle after done -> second frame starts, tx low 3 edges after the sampled press, gap >= 1 cycle.
- Reset mid-frame: assert reset_n during DATA bit 3 -> tx=1 and busy=0 asynchronously, no done. After release with send_n low, no frame until a release/press cycle.
